// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames from an asynchronous serial line into a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity mismatches on parity_err_o.
module uart_rx #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BIT_RATE = 9600
) (
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err_o
`endif
);

  localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state;
  state_t           state_d;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             tic;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             stop_tic;
  logic             frame_ok;

  // The line is asynchronous to clk_i; only the second flop's output is ever used.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      sync <= 2'b11;
    end else begin
      // NOTE: every sequential block uses non-blocking assignments so all flops update together on the edge.
      sync <= {sync[0], rx_i};
    end
  end

  assign rx_s = sync[1];

  // START waits half a bit so every later sample lands mid-bit.
  always_comb begin
    limit = CNT_W'(CLKS_PER_BIT);
    if (state == START) limit = CNT_W'(HALF_BIT);
  end

  assign tic      = (cnt == limit - 1'b1);
  assign stop_tic = (state == STOP) && tic;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    // NOTE: the default is assigned first so no path through the case leaves state_d unassigned (no latch).
    state_d = state;
    case (state)
      IDLE:   if (!rx_s) state_d = START;
      START:  if (tic) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (tic && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
      PARITY: if (tic) state_d = STOP;
      STOP:   if (tic) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      cnt <= '0;
    end else if (state == IDLE || state_d != state || tic) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      parity_err_o <= 1'b0;
      if (state == PARITY && tic) par_bit <= rx_s;
      if (stop_tic && (par_bit != ^shift)) parity_err_o <= 1'b1;
    end
  end

  assign frame_ok = rx_s && (par_bit == ^shift);
`else
  assign frame_ok = rx_s;
`endif

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      // NOTE: the shift register and holding register are reset too, so rx_data_o reads 8'h00 out of reset.
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      rx_data_o   <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (state == START && tic) bit_idx <= 3'd0;
      if (state == DATA && tic) begin
        shift[bit_idx] <= rx_s;
        bit_idx        <= bit_idx + 3'd1;
      end
      if (valid_o && ready_i) valid_o <= 1'b0;
      // A completion in the same cycle as a drain refills the register; the later assignment wins.
      if (stop_tic) begin
        if (!rx_s) frame_err_o <= 1'b1;
        if (frame_ok) begin
          if (!valid_o || ready_i) begin
            rx_data_o <= shift;
            valid_o   <= 1'b1;
          end else begin
            overrun_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames, expected bytes queued at issue time and
// compared by an independent monitor at each handshake; error pulses counted per cycle.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk;
  logic       nreset_i;
  logic       rx_i;
  logic [7:0] rx_data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_o;
`endif

  uart_rx #(.CLK_HZ(1_000_000), .BIT_RATE(100_000)) dut (
    .clk_i       (clk),
    .nreset_i    (nreset_i),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err_o(parity_err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         pe_cnt = 0;
  int         fe0, ov0, pe0;
  int         lat;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_i = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ par_flip);
`endif
    send_bit(stop_b);
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ready_i = r;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    pe0 = pe_cnt;
  endtask

  // Monitor: pulse counting, hold-stability while stalled, byte comparison at each handshake.
  initial begin
    logic       prev_v;
    logic       prev_r;
    logic [7:0] prev_d;
    prev_v = 1'b0;
    prev_r = 1'b0;
    prev_d = 8'h00;
    forever begin
      @(negedge clk);
      if (!nreset_i) begin
        prev_v = 1'b0;
      end else begin
        if (frame_err_o) fe_cnt++;
        if (overrun_o) ov_cnt++;
`ifdef UART_RX_PARITY_EN
        if (parity_err_o) pe_cnt++;
`endif
        if (prev_v && !prev_r) begin
          check("hold_valid", valid_o, 1);
          check("hold_data", rx_data_o, prev_d);
        end
        if (valid_o && ready_i) begin
          if (exp_q.size() > 0) begin
            check("rx_byte", rx_data_o, exp_q.pop_front());
          end else begin
            tests++;
            fails++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_data_o);
          end
        end
        prev_v = valid_o;
        prev_r = ready_i;
        prev_d = rx_data_o;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rx_i     = 1'b1;
    ready_i  = 1'b1;
    nreset_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", valid_o, 0);
    check("rst_data", rx_data_o, 8'h00);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_overrun", overrun_o, 0);
    @(negedge clk);
    nreset_i = 1'b1;
    idle(20);

    // 1: single byte, consumer always ready; valid one cycle after the mid-stop sample
    snap();
    exp_q.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        lat = 0;
        while (!valid_o && lat < 200) begin
          @(negedge clk);
          lat++;
        end
        check("t1_latency_window", (lat >= 95 && lat <= 100), 1);
        @(negedge clk);
        check("t1_valid_one_cycle", valid_o, 0);
      end
    join
    idle(20);
    check("t1_no_frame_err", fe_cnt - fe0, 0);
    check("t1_no_overrun", ov_cnt - ov0, 0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2: back-to-back frames with the consumer stalled; second byte overruns
    set_ready(1'b0);
    snap();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(20);
    check("t2_held_valid", valid_o, 1);
    check("t2_held_data", rx_data_o, 8'h3C);
    check("t2_overrun_once", ov_cnt - ov0, 1);
    check("t2_no_frame_err", fe_cnt - fe0, 0);
    set_ready(1'b1);
    @(negedge clk);
    check("t2_drained", valid_o, 0);
    check("t2_q_empty", exp_q.size(), 0);

    // 3: short low glitch is ignored; next frame is clean
    snap();
    rx_i = 1'b0;
    repeat (3) @(negedge clk);
    idle(30);
    check("t3_glitch_no_valid", valid_o, 0);
    check("t3_glitch_no_frame_err", fe_cnt - fe0, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    idle(20);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: low stop bit -> frame error only; following frame received
    snap();
    send_frame(8'h81, 1'b0, 1'b0);
    idle(20);
    check("t4_frame_err_once", fe_cnt - fe0, 1);
    check("t4_no_valid", valid_o, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(20);
    check("t4_q_empty", exp_q.size(), 0);
    check("t4_no_overrun", ov_cnt - ov0, 0);

    // 5: reset mid-frame with a byte held; outputs clear at once, receiver recovers
    set_ready(1'b0);
    exp_q.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b0);
    idle(10);
    check("t5_pre_valid", valid_o, 1);
    check("t5_pre_data", rx_data_o, 8'h99);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1 ^ i[0]);
    nreset_i = 1'b0;
    #1;
    check("t5_rst_valid", valid_o, 0);
    check("t5_rst_data", rx_data_o, 8'h00);
    check("t5_rst_frame_err", frame_err_o, 0);
    check("t5_rst_overrun", overrun_o, 0);
    exp_q.delete();
    rx_i = 1'b1;
    repeat (5) @(negedge clk);
    nreset_i = 1'b1;
    set_ready(1'b1);
    idle(30);
    snap();
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(20);
    check("t5_q_empty", exp_q.size(), 0);
    check("t5_no_frame_err", fe_cnt - fe0, 0);

`ifdef UART_RX_PARITY_EN
    // 6: even parity accepted, flipped parity reported and the byte discarded
    snap();
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
    check("t6_good_parity_q_empty", exp_q.size(), 0);
    check("t6_no_parity_err", pe_cnt - pe0, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    check("t6_parity_err_once", pe_cnt - pe0, 1);
    check("t6_bad_parity_no_valid", valid_o, 0);
    check("t6_no_frame_err", fe_cnt - fe0, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
